// File: rtl/msg_schedule_seq_pkg.sv
// Shared definitions for the SHA-256 message schedule sequencer.
// Contents: word and block sizes, FSM state encodings, and the rotate/shift
// amounts used by the small-sigma functions s0 and s1.
package msg_schedule_seq_pkg;

  localparam int SHA_WORD_W  = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int SCHED_WORDS = 64;

  // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;

  // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/msg_schedule_seq_sched_sigma.sv
// sched_sigma: combinational small-sigma function of the SHA-256 schedule,
//   y = ROTR(x, ROT_A) ^ ROTR(x, ROT_B) ^ (x >> SHR_C)
// Ports:
//   x : input word
//   y : sigma of x
module sched_sigma
  import msg_schedule_seq_pkg::*;
#(
  parameter int DATA_W = SHA_WORD_W,
  parameter int ROT_A  = S0_R1,
  parameter int ROT_B  = S0_R2,
  parameter int SHR_C  = S0_SH
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] rot_a;
  logic [DATA_W-1:0] rot_b;

  assign rot_a = (x >> ROT_A) | (x << (DATA_W - ROT_A));
  assign rot_b = (x >> ROT_B) | (x << (DATA_W - ROT_B));
  assign y     = rot_a ^ rot_b ^ (x >> SHR_C);

endmodule

// File: rtl/msg_schedule_seq.sv
// msg_schedule_seq: streams the 64-word SHA-256 message schedule W[0..63]
// for one 512-bit block. The first 16 words are taken from the input stream
// and echoed; the remaining 48 are expanded from a 16-word sliding window.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   run                       : start pulse (honoured only when idle)
//   done                      : one-cycle pulse after the last word is taken
//   busy                      : high while a block is in progress
//   in_valid/in_ready/in_data : message word input, M0 first
//   out_valid/out_ready       : schedule word output handshake
//   out_data/out_idx          : schedule word W[t] and its index t
module msg_schedule_seq
  import msg_schedule_seq_pkg::*;
#(
  parameter int DATA_W      = SHA_WORD_W,
  parameter int SCHED_WORDS = msg_schedule_seq_pkg::SCHED_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_idx
);

  state_e                               state_q, state_d;
  logic [5:0]                           cnt_q, cnt_d;
  logic [BLOCK_WORDS-1:0][DATA_W-1:0]   win_q, win_d;
  logic                                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]                    out_data_q, out_data_d;
  logic [5:0]                           out_idx_q, out_idx_d;
  logic                                 done_q, done_d;

  logic                                 load_en;
  logic [DATA_W-1:0]                    s0, s1, w_new;

  // win_q[15] is W[t-1], win_q[0] is W[t-16]
  sched_sigma #(.DATA_W(DATA_W), .ROT_A(S0_R1), .ROT_B(S0_R2), .SHR_C(S0_SH))
    u_s0 (.x(win_q[1]), .y(s0));
  sched_sigma #(.DATA_W(DATA_W), .ROT_A(S1_R1), .ROT_B(S1_R2), .SHR_C(S1_SH))
    u_s1 (.x(win_q[14]), .y(s1));

  assign w_new   = s1 + win_q[9] + s0 + win_q[0];

  // Output register may take a new word when empty or being drained this cycle
  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;

    // A consumed word with no replacement leaves the register empty
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        in_ready = load_en;
        if (in_valid && load_en) begin
          win_d       = {in_data, win_q[BLOCK_WORDS-1:1]};
          out_data_d  = in_data;
          out_idx_d   = cnt_q;
          out_valid_d = 1'b1;
          cnt_d       = 6'(cnt_q + 6'd1);
          if (cnt_q == 6'(BLOCK_WORDS - 1)) state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (load_en) begin
          win_d       = {w_new, win_q[BLOCK_WORDS-1:1]};
          out_data_d  = w_new;
          out_idx_d   = cnt_q;
          out_valid_d = 1'b1;
          cnt_d       = 6'(cnt_q + 6'd1);
          if (cnt_q == 6'(SCHED_WORDS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last word W[63] sits in the output register until taken
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_msg_schedule_seq.sv
module tb_msg_schedule_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        done, busy, in_ready, out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_idx;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];

  always #5 clk = ~clk;

  msg_schedule_seq #(.DATA_W(32), .SCHED_WORDS(64)) dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
    return (x >> r) | (x << (32 - r));
  endfunction

  // Textbook SHA-256 schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  function automatic void build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
               + exp_w[t-7]
               + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
               + exp_w[t-16];
  endfunction

  function automatic void set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
  endfunction

  // Runs one block; inputs and ready are driven at the falling edge, and a
  // handshake is recorded when valid&&ready hold just before the rising edge.
  task automatic drive_block(input bit rnd, input int stall_t, input int rerun_t,
                             input int abort_t, output int got, output int dones,
                             output int done_gap);
    int  sent, stall_n, last_hs;
    bit  junk_rdy, stalling;
    sent = 0; got = 0; dones = 0; stall_n = 0; last_hs = -100; done_gap = -1;
    junk_rdy = 0;
    for (int i = 0; i < 64; i++) obs_w[i] = 32'hxxxx_xxxx;
    @(negedge clk);
    run = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    run = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      // after 16 words in_valid stays high with junk, which must be ignored
      in_valid  = (sent < 16) ? (!rnd || ($urandom_range(0, 1) == 1)) : 1'b1;
      in_data   = (sent < 16) ? blk[sent] : 32'hDEAD_BEEF;
      out_ready = !rnd || ($urandom_range(0, 1) == 1);
      stalling  = 1'b0;
      if (got == stall_t && stall_n < 10) begin
        out_ready = 1'b0; stall_n++; stalling = 1'b1;
      end
      run = (got == rerun_t);
      #1;
      if (sent >= 16 && in_ready !== 1'b0) junk_rdy = 1'b1;
      if (in_valid && in_ready) sent++;
      if (stalling) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== exp_w[stall_t] || out_idx !== 6'(stall_t)) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d: got v=%b d=%h i=%0d, want v=1 d=%h i=%0d",
                   cyc, out_valid, out_data, out_idx, exp_w[stall_t], stall_t);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_chk++;
        if (got >= 64) begin
          n_fail++;
          $display("FAIL word_extra: got extra word d=%h i=%0d, want none", out_data, out_idx);
        end else begin
          obs_w[got] = out_data;
          if (out_data !== exp_w[got] || out_idx !== 6'(got)) begin
            n_fail++;
            $display("FAIL word t=%0d: got d=%h i=%0d, want d=%h i=%0d",
                     got, out_data, out_idx, exp_w[got], got);
          end
        end
        got++;
        last_hs = cyc;
      end
      if (done === 1'b1) begin
        dones++;
        done_gap = cyc - last_hs;
      end
      if (got == abort_t) begin
        rst = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_idx !== 6'd0 ||
            done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_reset: got v=%b d=%h i=%0d done=%b busy=%b ir=%b, want all 0",
                   out_valid, out_data, out_idx, done, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        break;
      end
      if (got >= 64 && cyc - last_hs >= 3) break;
      @(negedge clk);
    end
    run = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_chk++;
    if (junk_rdy) begin
      n_fail++;
      $display("FAIL in_ready_outside_load: got 1, want 0");
    end
  endtask

  task automatic check_block(input string name, input int got, input int dones,
                             input int done_gap);
    n_chk++;
    if (got !== 64) begin
      n_fail++;
      $display("FAIL %s word_count: got %0d, want 64", name, got);
    end
    n_chk++;
    if (dones !== 1 || done_gap !== 1) begin
      n_fail++;
      $display("FAIL %s done_pulse: got count=%0d gap=%0d, want count=1 gap=1",
               name, dones, done_gap);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after: got %b, want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_idx !== 6'd0 ||
        done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b d=%h i=%0d done=%b busy=%b ir=%b, want all 0",
               out_valid, out_data, out_idx, done, busy, in_ready);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_in: got busy=%b v=%b ir=%b, want 0 0 0",
               busy, out_valid, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abc();
    int got, dones, gap;
    set_abc(); build_model();
    drive_block(1'b0, -1, -1, -1, got, dones, gap);
    check_block("abc", got, dones, gap);
    n_chk++;
    if (obs_w[0] !== 32'h6162_6380 || obs_w[15] !== 32'h0000_0018 ||
        obs_w[16] !== 32'h6162_6380 || obs_w[17] !== 32'h000F_0000) begin
      n_fail++;
      $display("FAIL abc_anchor: got W0=%h W15=%h W16=%h W17=%h, want 61626380 00000018 61626380 000f0000",
               obs_w[0], obs_w[15], obs_w[16], obs_w[17]);
    end
  endtask

  task automatic test_zero();
    int got, dones, gap;
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    build_model();
    drive_block(1'b0, -1, -1, -1, got, dones, gap);
    check_block("zero", got, dones, gap);
    n_chk++;
    if (obs_w[63] !== 32'h0 || obs_w[40] !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_words: got W40=%h W63=%h, want 0 0", obs_w[40], obs_w[63]);
    end
  endtask

  task automatic test_random_flow();
    int got, dones, gap;
    set_abc(); build_model();
    drive_block(1'b1, -1, -1, -1, got, dones, gap);
    check_block("random_flow", got, dones, gap);
  endtask

  task automatic test_rerun();
    int got, dones, gap;
    set_abc(); build_model();
    drive_block(1'b0, -1, 30, -1, got, dones, gap);
    check_block("rerun", got, dones, gap);
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rerun_latched: got busy=%b v=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_abort();
    int got, dones, gap;
    set_abc(); build_model();
    drive_block(1'b0, -1, -1, 30, got, dones, gap);
    n_chk++;
    if (got !== 30 || dones !== 0) begin
      n_fail++;
      $display("FAIL abort_point: got words=%0d dones=%0d, want 30 0", got, dones);
    end
    drive_block(1'b0, -1, -1, -1, got, dones, gap);
    check_block("after_abort", got, dones, gap);
  endtask

  task automatic test_stall();
    int got, dones, gap;
    set_abc(); build_model();
    drive_block(1'b0, 20, -1, -1, got, dones, gap);
    check_block("stall", got, dones, gap);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_random_flow();
    test_rerun();
    test_abort();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
